// File: rtl/mem_stage.sv
// Memory-access stage: resolves redirects, runs lw/sw over a valid/ready port with a bounded wait,
// stalls upstream while an access is outstanding and registers the MEM/WB bundle.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs2,
  input  logic [31:0] immPc,
  input  logic [31:0] pcAdd4,
  input  logic [31:0] outAlu,
  input  logic [4:0]  rd,
  input  logic        EscReg,
  input  logic        EscMem,
  input  logic        jump,
  input  logic        Branch,
  input  logic        jalr,
  input  logic        lw,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic        memReady,
  input  logic [31:0] memRdata,
  output logic        stall,
  output logic        pcSel,
  output logic [31:0] pcTarget,
  output logic [31:0] wbData,
  output logic [4:0]  rdWb,
  output logic        EscRegWb,
  output logic        memErr
);

  typedef enum logic {IDLE, BUSY} state_t;

  // cnt holds the number of BUSY cycles already spent without memReady
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [4:0]  hold_rd;
  logic        hold_lw;
  logic        access, misaligned;
  logic        start, done, abort;

  assign access     = lw | EscMem;
  assign misaligned = access & (outAlu[1:0] != 2'b00);

  assign pcSel    = jump | jalr | (Branch & outAlu[0]);
  assign pcTarget = jalr ? {outAlu[31:1], 1'b0} : immPc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misaligned) begin
          start     = 1'b1;
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (memReady) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == LAST) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      hold_rd  <= '0;
      hold_lw  <= 1'b0;
      wbData   <= '0;
      rdWb     <= '0;
      EscRegWb <= 1'b0;
      memErr   <= 1'b0;
    end else begin
      // bubble by default: write enable low, wbData/rdWb hold
      EscRegWb <= 1'b0;
      memErr   <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          memReq   <= 1'b1;
          memWe    <= EscMem & ~lw;
          memAddr  <= outAlu;
          memWdata <= rs2;
          hold_rd  <= rd;
          hold_lw  <= lw;
          cnt      <= '0;
        end else if (misaligned) begin
          memErr <= 1'b1;
        end else begin
          wbData   <= (jump | jalr) ? pcAdd4 : outAlu;
          rdWb     <= rd;
          EscRegWb <= EscReg & (rd != 5'd0);
        end
      end else begin
        if (done) begin
          memReq <= 1'b0;
          if (hold_lw) begin
            wbData   <= memRdata;
            rdWb     <= hold_rd;
            EscRegWb <= 1'b1;
          end
        end else if (abort) begin
          memReq <= 1'b0;
          memErr <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs, resolves control-flow redirects, and runs loads and stores against a data memory with a valid/ready handshake and a bounded wait. It stalls upstream stages while an access is outstanding and drives the registered MEM/WB bundle to the writeback stage.

## Interface
- TIMEOUT, 255: maximum BUSY cycles before an access is aborted; 1..255.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rs2  in  32  store data.
- immPc  in  32  branch/jal target.
- pcAdd4  in  32  link value.
- outAlu  in  32  ALU result: address for lw/sw, compare result for branches (bit 0), jalr target.
- rd  in  5  destination register.
- EscReg, EscMem, jump, Branch, jalr, lw  in  1 each  control bits from EX/MEM.
- memReq  out  1  request valid, registered.
- memWe  out  1  1 = store, registered.
- memAddr  out  32  word-aligned byte address, registered.
- memWdata  out  32  store data, registered.
- memReady  in  1  memory accepts or completes the access this cycle.
- memRdata  in  32  load data, valid when memReady = 1.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; combinational.
- pcSel  out  1  redirect PC; combinational.
- pcTarget  out  32  redirect address; combinational.
- wbData  out  32  MEM/WB write data, registered.
- rdWb  out  5  MEM/WB destination, registered.
- EscRegWb  out  1  MEM/WB write enable, registered.
- memErr  out  1  one-cycle pulse on misalignment or timeout, registered.

## Operation
- access = lw | EscMem. When lw and EscMem are both 1, the access is a load.
- misaligned = access & (outAlu[1:0] != 0).
- FSM has two states: IDLE and BUSY.
  - IDLE, with access and not misaligned:
    - Latch memAddr = outAlu, memWdata = rs2, memWe = EscMem & ~lw.
    - Latch rd and lw into holding registers.
    - Clear the wait counter and go to BUSY.
  - BUSY:
    - memReq = 1 and the address/data/we outputs stay stable.
    - Counter increments every cycle in which memReady = 0.
    - memReady = 1: go to IDLE. For a load, wbData = memRdata, rdWb = held rd, EscRegWb = 1. For a store, EscRegWb = 0.
    - Counter reaches TIMEOUT with memReady = 0: go to IDLE, drop memReq, pulse memErr, EscRegWb = 0. memReady arriving in that same cycle wins over the timeout.
- stall = (IDLE & access & ~misaligned) | (BUSY & ~memReady).
- Misaligned access:
  - No request is issued and the FSM stays in IDLE.
  - memErr pulses next cycle; MEM/WB gets EscRegWb = 0.
- Non-access instruction in IDLE: the next edge registers the MEM/WB bundle.
  - wbData = pcAdd4 if jump | jalr, else outAlu.
  - rdWb = rd, EscRegWb = EscReg & (rd != 0).
- Bubble: in any cycle where stall = 1, or BUSY ends without a load writeback, MEM/WB gets EscRegWb = 0 and wbData, rdWb hold.
- Redirect is computed from the current inputs and does not depend on the FSM.
  - pcSel = jump | jalr | (Branch & outAlu[0]).
  - pcTarget = jalr ? {outAlu[31:1], 1'b0} : immPc.
- memReady in IDLE is ignored.

## Timing
- Reset values (asynchronous): state IDLE, counter 0, memReq 0, memWe 0, memAddr 0, memWdata 0, wbData 0, rdWb 0, EscRegWb 0, memErr 0.
- memReq drops in the reset cycle itself.
- Non-memory instruction: MEM/WB valid 1 cycle after it appears on the inputs.
- Load or store presented in cycle N:
  - stall = 1 in cycle N.
  - memReq = 1 from N+1.
  - memReady sampled at cycle M ≥ N+1.
  - stall = 0 in cycle M; load data appears on MEM/WB at M+1.
- Zero-wait memory (memReady = 1 at N+1) gives 2 stall-free... precisely, a total of 1 stall cycle (cycle N).
- Timeout: abort at the edge after cycle N+TIMEOUT; memErr is high for exactly 1 cycle.
- EX/MEM inputs are held stable by upstream while stall = 1. A reset in BUSY abandons the access with no writeback.

## Test plan
- ALU op, rd = 5, outAlu = 0x1234, EscReg = 1 -> next cycle wbData = 0x1234, rdWb = 5, EscRegWb = 1, stall never asserted.
- lw, outAlu = 0x100, memReady high 3 cycles after memReq rises, memRdata = 0xDEADBEEF -> memAddr = 0x100, memWe = 0, stall high 4 cycles, then wbData = 0xDEADBEEF, EscRegWb = 1.
- sw, outAlu = 0x204, rs2 = 0xCAFE0001, memReady at first BUSY cycle -> memWe = 1, memWdata = 0xCAFE0001, stall high 1 cycle, EscRegWb = 0.
- lw with outAlu = 0x102 -> memReq stays 0, memErr 1-cycle pulse, EscRegWb = 0, no stall.
- TIMEOUT = 4, lw, memReady held 0 -> memReq high 4 cycles, memErr pulse, FSM returns to IDLE, stall drops; a second case with memReady asserted on the 4th cycle completes the load normally.
- jalr with outAlu = 0x3001 -> pcSel = 1, pcTarget = 0x3000, wbData = pcAdd4. Branch with outAlu = 0 -> pcSel = 0. Reset asserted mid-BUSY -> memReq = 0 immediately and all outputs at their reset values.
